// File: rtl/unix_to_date.sv
// unix_to_date: iterative seconds-since-epoch to UTC calendar date/time converter.
// Latency is data-dependent, at most about 8170 cycles; start is ignored while busy. Optional macro: UNIX_WEEKDAY_EN.
module unix_to_date (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] unix_time,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] year,
    output logic [3:0]  month,
    output logic [4:0]  day,
    output logic [4:0]  hour,
    output logic [5:0]  minute,
    output logic [5:0]  second,
    output logic [2:0]  weekday
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] HOUR  = 3'd3;
    localparam logic [2:0] MIN   = 3'd4;
    localparam logic [2:0] YEAR  = 3'd5;
    localparam logic [2:0] MONTH = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    // First second of year 10000; everything below fits in a 38-bit dividend.
    localparam logic [63:0] TIME_LIMIT  = 64'd253402300800;
    localparam logic [17:0] SEC_PER_DAY = 18'd86400;

    logic [2:0]  state;
    logic [63:0] t_cap;
    logic [37:0] dvd;
    logic [17:0] rem;
    logic [21:0] days;
    logic [5:0]  bit_cnt;
    logic [4:0]  hr_w;
    logic [5:0]  mn_w;
    logic [15:0] yr_w;
    logic [3:0]  mo_w;

    logic [17:0] rem_sh;
    logic        is_leap;
    logic [8:0]  year_len;
    logic [4:0]  mon_len;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                      month_len = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   month_len = 5'd30;
            default:                   month_len = 5'd31;
        endcase
    endfunction

    always_comb begin
        rem_sh   = {rem[16:0], dvd[37]};
        is_leap  = ((yr_w % 16'd4 == 16'd0) && (yr_w % 16'd100 != 16'd0)) || (yr_w % 16'd400 == 16'd0);
        year_len = is_leap ? 9'd366 : 9'd365;
        mon_len  = month_len(mo_w, is_leap);
    end

`ifdef UNIX_WEEKDAY_EN
    logic [2:0] wd_w;
    logic [2:0] wd_q;

    function automatic logic [2:0] wd_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        wd_add = (s >= 4'd7) ? 3'(s - 4'd7) : s[2:0];
    endfunction

    assign weekday = wd_q;
`else
    assign weekday = 3'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            year    <= 16'd1970;
            month   <= 4'd1;
            day     <= 5'd1;
            hour    <= 5'd0;
            minute  <= 6'd0;
            second  <= 6'd0;
            t_cap   <= '0;
            dvd     <= '0;
            rem     <= '0;
            days    <= '0;
            bit_cnt <= '0;
            hr_w    <= '0;
            mn_w    <= '0;
            yr_w    <= 16'd1970;
            mo_w    <= 4'd1;
`ifdef UNIX_WEEKDAY_EN
            wd_w    <= 3'd4;
            wd_q    <= 3'd4;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    t_cap <= unix_time;
                    busy  <= 1'b1;
                    state <= CHECK;
                end
                CHECK: if (t_cap >= TIME_LIMIT) begin
                    err   <= 1'b1;
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    err     <= 1'b0;
                    dvd     <= t_cap[37:0];
                    rem     <= '0;
                    days    <= '0;
                    bit_cnt <= 6'd37;
                    state   <= DIV;
                end
                DIV: begin
                    // Quotient never exceeds 22 bits, so bits shifted off the top are zero.
                    if (rem_sh >= SEC_PER_DAY) begin
                        rem  <= rem_sh - SEC_PER_DAY;
                        days <= {days[20:0], 1'b1};
                    end else begin
                        rem  <= rem_sh;
                        days <= {days[20:0], 1'b0};
                    end
                    dvd <= {dvd[36:0], 1'b0};
                    if (bit_cnt == 6'd0) begin
                        hr_w  <= '0;
                        state <= HOUR;
                    end else begin
                        bit_cnt <= bit_cnt - 6'd1;
                    end
                end
                HOUR: if (rem >= 18'd3600) begin
                    rem  <= rem - 18'd3600;
                    hr_w <= hr_w + 5'd1;
                end else begin
                    mn_w  <= '0;
                    state <= MIN;
                end
                MIN: if (rem >= 18'd60) begin
                    rem  <= rem - 18'd60;
                    mn_w <= mn_w + 6'd1;
                end else begin
                    yr_w  <= 16'd1970;
`ifdef UNIX_WEEKDAY_EN
                    wd_w  <= 3'd4;
`endif
                    state <= YEAR;
                end
                YEAR: if (days >= {13'd0, year_len}) begin
                    days <= days - {13'd0, year_len};
                    yr_w <= yr_w + 16'd1;
`ifdef UNIX_WEEKDAY_EN
                    wd_w <= wd_add(wd_w, is_leap ? 3'd2 : 3'd1);
`endif
                end else begin
                    mo_w  <= 4'd1;
                    state <= MONTH;
                end
                MONTH: if (days >= {17'd0, mon_len}) begin
                    days <= days - {17'd0, mon_len};
                    mo_w <= mo_w + 4'd1;
`ifdef UNIX_WEEKDAY_EN
                    // Month length mod 7 is simply its excess over 28.
                    wd_w <= wd_add(wd_w, 3'(mon_len - 5'd28));
`endif
                end else begin
                    year   <= yr_w;
                    month  <= mo_w;
                    day    <= days[4:0] + 5'd1;
                    hour   <= hr_w;
                    minute <= mn_w;
                    second <= rem[5:0];
`ifdef UNIX_WEEKDAY_EN
                    wd_q   <= 3'((6'(wd_w) + 6'(days[4:0])) % 6'd7);
`endif
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_unix_to_date.sv
// Testbench for unix_to_date: directed boundary dates plus random epochs checked
// against a closed-form civil-calendar model.
module tb_unix_to_date;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] unix_time;
    logic        busy, done, err;
    logic [15:0] year;
    logic [3:0]  month;
    logic [4:0]  day, hour;
    logic [5:0]  minute, second;
    logic [2:0]  weekday;

    int checks = 0;
    int errors = 0;

    logic [15:0] e_year;
    logic [3:0]  e_month;
    logic [4:0]  e_day, e_hour;
    logic [5:0]  e_minute, e_second;
    logic [2:0]  e_wd;

    unix_to_date dut (
        .clk(clk), .reset(reset), .start(start), .unix_time(unix_time),
        .busy(busy), .done(done), .err(err),
        .year(year), .month(month), .day(day), .hour(hour),
        .minute(minute), .second(second), .weekday(weekday)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Civil date from day count (days-from-civil inverse, era-based).
    task automatic model(input logic [63:0] t);
        longint days, sod, z, era, doe, yoe, y, doy, mp, d, m;
        days = longint'(t / 64'd86400);
        sod  = longint'(t % 64'd86400);
        z    = days + 719468;
        era  = z / 146097;
        doe  = z - era * 146097;
        yoe  = (doe - doe / 1460 + doe / 36524 - doe / 146096) / 365;
        y    = yoe + era * 400;
        doy  = doe - (365 * yoe + yoe / 4 - yoe / 100);
        mp   = (5 * doy + 2) / 153;
        d    = doy - (153 * mp + 2) / 5 + 1;
        m    = (mp < 10) ? mp + 3 : mp - 9;
        if (m <= 2) y++;
        e_year   = 16'(y);
        e_month  = 4'(m);
        e_day    = 5'(d);
        e_hour   = 5'(sod / 3600);
        e_minute = 6'((sod % 3600) / 60);
        e_second = 6'(sod % 60);
`ifdef UNIX_WEEKDAY_EN
        e_wd     = 3'((days + 4) % 7);
`else
        e_wd     = 3'd0;
`endif
    endtask

    task automatic check_fields(input string tag);
        chk({tag, "_year"},    64'(year),    64'(e_year));
        chk({tag, "_month"},   64'(month),   64'(e_month));
        chk({tag, "_day"},     64'(day),     64'(e_day));
        chk({tag, "_hour"},    64'(hour),    64'(e_hour));
        chk({tag, "_minute"},  64'(minute),  64'(e_minute));
        chk({tag, "_second"},  64'(second),  64'(e_second));
        chk({tag, "_weekday"}, 64'(weekday), 64'(e_wd));
    endtask

    task automatic check_reset_state(input string tag);
        e_year = 16'd1970; e_month = 4'd1; e_day = 5'd1;
        e_hour = 5'd0; e_minute = 6'd0; e_second = 6'd0;
`ifdef UNIX_WEEKDAY_EN
        e_wd = 3'd4;
`else
        e_wd = 3'd0;
`endif
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"},  64'(err),  64'd0);
        check_fields(tag);
    endtask

    // One start pulse, optional second start injected while busy; returns edges until done.
    task automatic convert(input string tag, input logic [63:0] t, input bit inject,
                           input logic [63:0] inj_t, output int lat);
        logic [44:0] snap;
        bit          held_ok;
        int          dones;
        snap    = {year, month, day, hour, minute, second, weekday};
        held_ok = 1'b1;
        dones   = 0;
        lat     = 0;
        unix_time = t;
        start     = 1'b1;
        while (dones == 0 && lat < 9000) begin
            @(posedge clk); #1;
            lat++;
            if (inject && lat == 5) begin
                start     = 1'b1;
                unix_time = inj_t;
            end else begin
                start = 1'b0;
            end
            if (done) dones++;
            else if ({year, month, day, hour, minute, second, weekday} !== snap) held_ok = 1'b0;
        end
        chk({tag, "_in_time"}, 64'(lat <= 8200), 64'd1);
        chk({tag, "_held"}, 64'(held_ok), 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk({tag, "_done_pulses"}, 64'(dones), 64'd1);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic good_case(input string tag, input logic [63:0] t);
        int lat;
        convert(tag, t, 1'b0, 64'd0, lat);
        model(t);
        chk({tag, "_err"}, 64'(err), 64'd0);
        check_fields(tag);
    endtask

    initial begin
        int          lat;
        int          dones;
        logic [63:0] t;
        logic [63:0] dir [5];
        dir = '{64'd0, 64'd951782400, 64'd4107542399, 64'd4107542400, 64'd253402300799};

        reset = 1'b1; start = 1'b0; unix_time = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (dir[i]) good_case($sformatf("dir%0d", i), dir[i]);

        // Out of range: fast error, previous date retained.
        convert("oor", 64'd253402300800, 1'b0, 64'd0, lat);
        chk("oor_latency", 64'(lat), 64'd2);
        chk("oor_err", 64'(err), 64'd1);
        check_fields("oor");
        t = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        convert("oor_big", t, 1'b0, 64'd0, lat);
        chk("oor_big_err", 64'(err), 64'd1);
        check_fields("oor_big");

        // Start while busy is ignored.
        convert("inject", 64'd1234567890, 1'b1, 64'd4000000000, lat);
        model(64'd1234567890);
        chk("inject_err", 64'(err), 64'd0);
        check_fields("inject");

        // Reset deep inside the year loop.
        unix_time = 64'd253402300799;
        start = 1'b1;
        dones = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) dones++;
        end
        chk("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_state("abort");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        good_case("after_abort", 64'd5184000 + 64'd86399);

        for (int i = 0; i < 12; i++) good_case($sformatf("rnd32_%0d", i), 64'($urandom));
        for (int i = 0; i < 3; i++) begin
            t = {$urandom, $urandom} % 64'd253402300800;
            good_case($sformatf("rndfull_%0d", i), t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/unix_to_date.md
UNIX_TO_DATE -- requirements
Module: unix_to_date

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request a conversion of unix_time.
REQ-004 SHALL have port unix_time, input, 64 bits: seconds since 1970-01-01 00:00:00 UTC, unsigned.
REQ-005 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse marking completion.
REQ-007 SHALL have port err, output, 1 bit: high when the last conversion was out of range.
REQ-008 SHALL have these outputs: year (16 bits), month (4 bits, 1-12), day (5 bits, 1-31), hour (5 bits), minute (6 bits), second (6 bits).
REQ-009 SHALL have port weekday, output, 3 bits: 0 = Sunday through 6 = Saturday.

Function
REQ-010 SHALL implement states IDLE, CHECK, DIV, HOUR, MIN, YEAR, MONTH and DONE.
REQ-011 SHALL accept start only in IDLE; accepting it captures unix_time, sets busy=1 and moves to CHECK on the same edge.
REQ-012 SHALL ignore start while busy=1, with no effect on the captured value or outputs.
REQ-013 SHALL, in CHECK, go to DONE with err=1 when the captured value is >= 253402300800; otherwise it clears err and goes to DIV.
REQ-014 SHALL, in DIV, perform a 38-bit restoring division by 86400 at one bit per cycle (38 cycles), yielding a day count and seconds-of-day.
REQ-015 SHALL, in HOUR, subtract 3600 once per cycle while the remainder is >= 3600, counting hours; MIN then does the same with 60; the final remainder is second.
REQ-016 SHALL, in YEAR, start from 1970 and subtract the year length once per cycle while days >= length.
REQ-017 SHALL use Gregorian year lengths: 366 if the year is divisible by 4 and not by 100, or divisible by 400; otherwise 365.
REQ-018 SHALL, in MONTH, subtract month lengths once per cycle from January, with February 29 days in leap years; day is the remaining value + 1.
REQ-019 SHALL hold all date/time outputs stable during conversion and update them together on entry to DONE, only on a successful conversion.
REQ-020 SHALL leave the date/time outputs at their previous values on err=1.
REQ-021 SHALL, in DONE, assert done for exactly one cycle, clear busy and return to IDLE; a start in the done cycle is ignored.
REQ-022 SHALL complete in at most 8200 cycles from start to done, with latency data-dependent.
REQ-023 SHALL keep outputs held until the next successful done.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, enter IDLE and set: busy=0, done=0, err=0, year=1970, month=1, day=1, hour=0, minute=0, second=0, weekday=4.
REQ-025 SHALL abort any in-progress conversion on reset with no done pulse, and reset SHALL take priority over start.

Configuration
REQ-026 SHALL use macro UNIX_WEEKDAY_EN: when defined, weekday = (days + 4) mod 7, computed incrementally during YEAR and MONTH and updated at DONE.
REQ-027 SHALL, when UNIX_WEEKDAY_EN is undefined, keep the weekday port present and drive it to constant 0, with no weekday logic; all other behaviour is unchanged.

Verification
REQ-028 SHALL cover: unix_time=0 -> 1970-01-01 00:00:00, weekday 4, err 0.
REQ-029 SHALL cover: unix_time=951782400 -> 2000-02-29 00:00:00, weekday 2; then 4107542399 -> 2100-02-28 23:59:59, and 4107542400 -> 2100-03-01 00:00:00, weekday 1.
REQ-030 SHALL cover: unix_time=253402300799 -> 9999-12-31 23:59:59, err 0; then 253402300800 -> done 2 cycles after start, err 1, date outputs unchanged.
REQ-031 SHALL cover: a start pulse while busy with a different unix_time -> ignored, and the first result is reported with a single done pulse.
REQ-032 SHALL cover: reset asserted during YEAR -> next cycle IDLE with REQ-024 values and no done; a new start then converts correctly.
REQ-033 SHALL cover: a build without UNIX_WEEKDAY_EN -> weekday stays 0 for all REQ-028/029 cases while the other fields match.
